alu_muldiv_seq: RTL and testbench

- Iterative sequencer that implements RV32M multiply/divide by time-sharing the existing 32-bit combinational ALU: add for multiply, subtract for divide.
- Sits beside the EX stage. Drives the ALU operand/control mux while it owns the ALU (alu_req=1), and holds the pipeline via busy.
- One operation in flight; fixed latency; single-cycle done pulse with result.

---
 rtl/alu_muldiv_seq.sv | 209 ++++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// RV32M multiply/divide sequencer that time-shares the EX-stage 32-bit ALU.
// Signed ops (PREP/FIX states) are built only when ALU_MULDIV_SIGNED_EN is defined.
module alu_muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            alu_req,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_result
);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   hi_q, hi_d;     // product high word / remainder
  logic [XLEN-1:0]   lo_q, lo_d;     // multiplier shifting out / quotient shifting in
  logic [XLEN-1:0]   opnd_q, opnd_d; // multiplicand / divisor
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              alu_req_q, alu_req_d;

  logic [XLEN-1:0]   div_rs, mul_sum, step_hi, step_lo;
  logic              div_take, mul_carry;

`ifdef ALU_MULDIV_SIGNED_EN
  logic              neg_q, neg_d;
  logic              sgn_lo, sgn_op;
  logic [XLEN-1:0]   fix_sel, fix_b;
`endif

  // MUL and quotients live in lo; high products and remainders in hi.
  function automatic logic [XLEN-1:0] res_sel(input logic [2:0] o,
                                              input logic [XLEN-1:0] h,
                                              input logic [XLEN-1:0] l);
    if (o[2]) return o[1] ? h : l;
    return (o == 3'b000) ? l : h;
  endfunction

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign alu_req = alu_req_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    alu_req_d = alu_req_q;
    alu_a     = '0;
    alu_b     = '0;
    alu_ctrl  = 3'b000;

    div_rs    = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
    div_take  = 1'b0;
    mul_sum   = hi_q;
    mul_carry = 1'b0;
    if (op_q[2]) begin
      div_take = hi_q[XLEN-1] | (div_rs >= opnd_q);
      step_hi  = div_take ? alu_result : div_rs;
      step_lo  = {lo_q[XLEN-2:0], div_take};
    end else begin
      if (lo_q[0]) begin
        mul_sum   = alu_result;
        mul_carry = alu_result < hi_q;
      end
      step_hi = {mul_carry, mul_sum[XLEN-1:1]};
      step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end

`ifdef ALU_MULDIV_SIGNED_EN
    neg_d   = neg_q;
    sgn_lo  = lo_q[XLEN-1] & (op_q[2] ? ~op_q[0] : (op_q == 3'b001));
    sgn_op  = opnd_q[XLEN-1] & (op_q[2] ? ~op_q[0] : (op_q == 3'b001 || op_q == 3'b010));
    fix_sel = res_sel(op_q, hi_q, lo_q);
    // -{hi,lo} high word = 0 - (hi + borrow from the low word)
    fix_b   = op_q[2] ? fix_sel : hi_q + {{(XLEN-1){1'b0}}, |lo_q};
`endif

    if (state_q == S_RUN) begin
      alu_a    = op_q[2] ? div_rs : hi_q;
      alu_b    = opnd_q;
      alu_ctrl = op_q[2] ? 3'b001 : 3'b000;
    end
`ifdef ALU_MULDIV_SIGNED_EN
    else if (state_q == S_FIX) begin
      alu_b    = fix_b;
      alu_ctrl = 3'b001;
    end
`endif

    if (kill && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      busy_d    = 1'b0;
      alu_req_d = 1'b0;
      cnt_d     = '0;
    end else begin
      case (state_q)
        S_IDLE: if (start && !kill) begin
          op_d  = op;
          cnt_d = '0;
          hi_d  = '0;
          if (op[2] && rs2 == '0) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = op[1] ? rs1 : '1;
          end else begin
            opnd_d = op[2] ? rs2 : rs1;
            lo_d   = op[2] ? rs1 : rs2;
            busy_d = 1'b1;
`ifdef ALU_MULDIV_SIGNED_EN
            state_d = S_PREP;
`else
            state_d   = S_RUN;
            alu_req_d = 1'b1;
`endif
          end
        end
`ifdef ALU_MULDIV_SIGNED_EN
        S_PREP: begin
          lo_d      = sgn_lo ? '0 - lo_q : lo_q;
          opnd_d    = sgn_op ? '0 - opnd_q : opnd_q;
          neg_d     = (op_q[2] && op_q[1]) ? sgn_lo : (sgn_lo ^ sgn_op);
          state_d   = S_RUN;
          alu_req_d = 1'b1;
        end
        S_FIX: begin
          result_d  = neg_q ? alu_result : fix_sel;
          state_d   = S_DONE;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          alu_req_d = 1'b0;
        end
`endif
        S_RUN: begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN-1)) begin
`ifdef ALU_MULDIV_SIGNED_EN
            state_d = S_FIX;
`else
            state_d   = S_DONE;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            alu_req_d = 1'b0;
            result_d  = res_sel(op_q, step_hi, step_lo);
`endif
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      alu_req_q <= 1'b0;
`ifdef ALU_MULDIV_SIGNED_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      alu_req_q <= alu_req_d;
`ifdef ALU_MULDIV_SIGNED_EN
      neg_q     <= neg_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomized self-checking bench for alu_muldiv_seq against an arithmetic reference model.
module tb_alu_muldiv_seq;
  logic        clk = 1'b0;
  logic        rst, start, kill;
  logic [2:0]  op_i;
  logic [31:0] rs1_i, rs2_i;
  logic        busy, done, alu_req;
  logic [31:0] result, alu_a, alu_b, alu_result;
  logic [2:0]  alu_ctrl;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_res = '0;

`ifdef ALU_MULDIV_SIGNED_EN
  localparam int LAT = 35;
`else
  localparam int LAT = 33;
`endif

  always #5 clk = ~clk;

  // Stand-in for the shared EX-stage ALU
  assign alu_result = (alu_ctrl == 3'b001) ? alu_a - alu_b : alu_a + alu_b;

  alu_muldiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op_i), .rs1(rs1_i), .rs2(rs2_i),
    .kill(kill), .busy(busy), .done(done), .result(result), .alu_req(alu_req),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] pu;
    longint      ps, psu;
    pu  = {32'b0, a} * {32'b0, b};
    ps  = longint'($signed(a)) * longint'($signed(b));
    psu = longint'($signed(a)) * longint'({32'b0, b});
    if (o[2] && b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
`ifdef ALU_MULDIV_SIGNED_EN
    case (o)
      3'd0: return pu[31:0];
      3'd1: return ps[63:32];
      3'd2: return psu[63:32];
      3'd3: return pu[63:32];
      3'd4: return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000
                   : $signed(a) / $signed(b);
      3'd5: return a / b;
      3'd6: return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0
                   : $signed(a) % $signed(b);
      default: return a % b;
    endcase
`else
    if (o == 3'd0) return pu[31:0];
    if (!o[2]) return pu[63:32];
    return o[1] ? a % b : a / b;
`endif
  endfunction

  // Issue one op and follow it to its done pulse; noise=1 keeps start toggling
  // with junk operands from cycle 2 through the done cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit noise);
    logic [31:0] exp;
    int exp_lat, cyc, nbusy, nadd, nreq;
    bit div0;
    div0    = o[2] && (b == 32'd0);
    exp     = ref_res(o, a, b);
    exp_lat = div0 ? 1 : LAT;
    start = 1'b1; op_i = o; rs1_i = a; rs2_i = b;
    tick();
    start = 1'b0;
    cyc = 1; nbusy = 0; nadd = 0; nreq = 0;
    while (!done && cyc < 60) begin
      if (busy) nbusy++;
      if (alu_req) nreq++;
      if (alu_req && alu_ctrl == 3'b000) nadd++;
      if (noise && cyc >= 2) begin
        start = 1'b1; op_i = 3'($urandom); rs1_i = $urandom; rs2_i = $urandom;
      end
      tick();
      cyc++;
    end
    chk($sformatf("lat op%0d", o), 32'(cyc), 32'(exp_lat));
    chk($sformatf("res op%0d %08h,%08h", o, a, b), result, exp);
    chk("busy_cycles", 32'(nbusy), div0 ? 32'd0 : 32'(LAT - 1));
    chk("busy_at_done", {31'b0, busy}, 32'd0);
    if (!o[2]) chk("add_cycles", 32'(nadd), 32'd32);
    if (div0) chk("div0_req", 32'(nreq), 32'd0);
    tick();
    start = 1'b0;
    chk("done_pulse", {31'b0, done}, 32'd0);
    chk("res_hold", result, exp);
    if (noise) begin
      tick();
      chk("noise_idle", {31'b0, busy}, 32'd0);
    end
    last_res = exp;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int ndone;
    rst = 1'b1; start = 1'b0; kill = 1'b0; op_i = '0; rs1_i = '0; rs2_i = '0;
    repeat (3) tick();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_alu", {alu_req, alu_ctrl, alu_a[27:0]} | alu_b, 32'd0);
    rst = 1'b0;
    tick();

    run_op(3'd0, 32'd7, 32'd6, 1'b0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd5, 32'd100, 32'd7, 1'b0);
    run_op(3'd7, 32'd100, 32'd7, 1'b0);
    run_op(3'd5, 32'd5, 32'd0, 1'b0);
    run_op(3'd6, 32'd5, 32'd0, 1'b0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd1, 32'hFFFF_FFFD, 32'd5, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd0, 32'd123, 32'd456, 1'b1);

    // kill mid-multiply at cycle 10
    start = 1'b1; op_i = 3'd0; rs1_i = 32'd3; rs2_i = 32'd5;
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kill_busy", {31'b0, busy}, 32'd0);
    ndone = 0;
    for (int c = 0; c < 45; c++) begin
      if (done || busy) ndone++;
      tick();
    end
    chk("kill_no_done", 32'(ndone), 32'd0);
    chk("kill_res", result, last_res);

    // kill beats start in IDLE
    start = 1'b1; kill = 1'b1; op_i = 3'd0; rs1_i = 32'd9; rs2_i = 32'd9;
    tick();
    start = 1'b0; kill = 1'b0;
    chk("kill_start_busy", {31'b0, busy}, 32'd0);

    // reset mid-RUN at cycle 15
    start = 1'b1; op_i = 3'd3; rs1_i = 32'hDEAD_BEEF; rs2_i = 32'h1234_5678;
    tick();
    start = 1'b0;
    for (int c = 1; c < 15; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", {31'b0, busy}, 32'd0);
    chk("mrst_result", result, 32'd0);
    chk("mrst_alu", {alu_req, done, alu_ctrl, alu_a[26:0]} | alu_b, 32'd0);
    run_op(3'd5, 32'd1000, 32'd33, 1'b0);

    for (int i = 0; i < 40; i++)
      run_op(3'($urandom_range(0, 7)), pick(), pick(), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
